// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
//   Shared types and helpers for the registered N-to-1 stream multiplexer.
//   mux_mode_t   : external select vs. round-robin arbitration
//   lock_state_t : packet-lock state (IDLE between packets, LOCKED mid-packet)
//   wrap_inc     : (v + 1) mod n for channel indices
package stream_mux_pkg;

    typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t;
    typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// rr_arbiter
//   Purely combinational rotate-priority search. Picks the first set bit of
//   req starting at index ptr and wrapping N-1 -> 0. Holds no state; the
//   pointer is owned by the caller.
// Ports:
//   req       [N]      request vector
//   ptr       [SEL_W]  highest-priority index (must be < N)
//   gnt_valid          at least one request set
//   gnt_idx   [SEL_W]  granted index (0 when gnt_valid=0)
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest requester
    // (smallest rotation from ptr) is the last write and wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n
//   Registered N-to-1 valid/ready stream mux with packet lock. The grant is
//   chosen by external select (mode=0) or round-robin (mode=1) while IDLE and
//   held until the granted channel's last beat has been accepted.
// Ports:
//   clk, rst_n          clock (rising), async active-low reset
//   mode, sel           0 = use sel, 1 = round-robin; sel ignored in RR
//   in_valid/last/data  N producer channels, data packed i*WIDTH +: WIDTH
//   in_ready            one-hot (or zero) ready back to producers
//   out_valid/data/last/ch  single output register and its source channel
//   out_ready           consumer ready
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);

    lock_state_t      state;
    logic [SEL_W-1:0] grant_q;
    logic [SEL_W-1:0] rr_ptr;

    logic             arb_vld;
    logic [SEL_W-1:0] arb_idx;

    logic             space;
    logic             g_vld;
    logic [SEL_W-1:0] g;
    logic             g_in_valid;
    logic             g_last;
    logic [WIDTH-1:0] g_data;
    logic             xfer;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (arb_vld),
        .gnt_idx   (arb_idx)
    );

    // Ready is held low during reset so producers never see a handshake
    // that the register bank is not able to take.
    assign space = (!out_valid || out_ready) && rst_n;

    // Effective grant: lock wins, otherwise the mode picks a candidate.
    always_comb begin
        g_vld = 1'b0;
        g     = '0;
        if (state == ST_LOCKED) begin
            g_vld = 1'b1;
            g     = grant_q;
        end else if (mux_mode_t'(mode) == MODE_RR) begin
            g_vld = arb_vld;
            g     = arb_idx;
        end else if (int'(sel) < N) begin
            // sel >= N only reachable when N is not a power of two
            g_vld = 1'b1;
            g     = sel;
        end
    end

    // Steer the granted channel; ready depends only on grant and space,
    // never on the same channel's valid.
    always_comb begin
        g_in_valid = 1'b0;
        g_last     = 1'b0;
        g_data     = '0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (g_vld && g == SEL_W'(i)) begin
                g_in_valid  = in_valid[i];
                g_last      = in_last[i];
                g_data      = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = space;
            end
        end
    end

    assign xfer = g_vld && g_in_valid && space;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            state     <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= g_data;
                out_last  <= g_last;
                out_ch    <= g;
                if (g_last) begin
                    // Packet end: release the lock and rotate priority past
                    // the channel that just finished.
                    state  <= ST_IDLE;
                    rr_ptr <= SEL_W'(wrap_inc(int'(g), N));
                end else begin
                    state   <= ST_LOCKED;
                    grant_q <= g;
                end
            end else if (out_ready) begin
                // Drain only; data/last/ch keep the last beat.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n
//   Scoreboard bench: per-channel source queues feed the mux, expected beats
//   are queued in the order the traffic pattern dictates, and every consumed
//   output beat is popped and compared. A second N=3 instance covers the
//   out-of-range select case.
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic           mode = 1'b0;
    logic [1:0]     sel = '0;
    logic [N-1:0]   in_valid, in_last, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_last, out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;

    // N=3 instance
    logic           mode3 = 1'b0;
    logic [1:0]     sel3 = '0;
    logic [2:0]     in_valid3 = '0, in_last3 = '0, in_ready3;
    logic [3*W-1:0] in_data3 = '0;
    logic           out_valid3, out_last3, out_ready3 = 1'b1;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_ch3;

    stream_mux_n #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
    );

    stream_mux_n #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_last(in_last3), .in_data(in_data3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_last(out_last3), .out_ch(out_ch3), .out_ready(out_ready3)
    );

    beat_t src_q[N][$];
    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]       = (src_q[i].size() != 0);
            in_last[i]        = in_valid[i] ? src_q[i][0].last : 1'b0;
            in_data[i*W +: W] = in_valid[i] ? src_q[i][0].data : '0;
        end
    endtask

    task automatic push_src(input int ch, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.ch = 2'(ch); b.data = d; b.last = l;
        src_q[ch].push_back(b);
    endtask

    task automatic push_exp(input int ch, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.ch = 2'(ch); b.data = d; b.last = l;
        exp_q.push_back(b);
    endtask

    // One clock: sample handshakes and consumed output at the falling edge,
    // then retire accepted source beats just after the rising edge.
    task automatic step();
        logic [N-1:0] fire;
        beat_t b;
        @(negedge clk);
        fire = in_valid & in_ready;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("sb_ch", 64'(out_ch), 64'(b.ch));
                chk("sb_data", 64'(out_data), 64'(b.data));
                chk("sb_last", 64'(out_last), 64'(b.last));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // 1: external select, single-beat packet on ch2
        mode = 1'b0; sel = 2'd2;
        push_src(2, 16'hA5A5, 1'b1);
        push_exp(2, 16'hA5A5, 1'b1);
        drive();
        #1;
        chk("t1_in_ready", 64'(in_ready), 64'b0100);
        step();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'hA5A5);
        chk("t1_out_ch", 64'(out_ch), 64'd2);
        chk("t1_out_last", 64'(out_last), 64'd1);
        chk("t1_state", 64'(dut.state), 64'(ST_IDLE));
        chk("t1_rr_ptr", 64'(dut.rr_ptr), 64'd3);
        drain(10);

        // 2: round-robin over four single-beat sources, fresh pointer
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < N; i++) push_src(i, 16'h1000 + 16'(i), 1'b1);
        push_src(0, 16'h1004, 1'b1);
        for (int i = 0; i < N; i++) push_exp(i, 16'h1000 + 16'(i), 1'b1);
        push_exp(0, 16'h1004, 1'b1);
        drive();
        #1;
        chk("t2_in_ready0", 64'(in_ready), 64'b0001);
        for (int k = 0; k < 5; k++) step();
        chk("t2_src_left", 64'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 64'd0);
        drain(10);

        // 3: 3-beat packet on ch1 holds the lock against ch0/ch3
        push_src(1, 16'h2001, 1'b0);
        push_src(1, 16'h2002, 1'b0);
        push_src(1, 16'h2003, 1'b1);
        push_src(0, 16'h2100, 1'b1);
        push_src(3, 16'h2300, 1'b1);
        push_exp(1, 16'h2001, 1'b0);
        push_exp(1, 16'h2002, 1'b0);
        push_exp(1, 16'h2003, 1'b1);
        push_exp(3, 16'h2300, 1'b1);
        push_exp(0, 16'h2100, 1'b1);
        drive();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_in_ready_lock", 64'(in_ready), 64'b0010);
            step();
        end
        drain(20);

        // 4: back-pressure for 5 cycles on a held beat
        mode = 1'b0; sel = 2'd1;
        push_src(1, 16'hB001, 1'b0);
        push_src(1, 16'hB002, 1'b1);
        push_exp(1, 16'hB001, 1'b0);
        push_exp(1, 16'hB002, 1'b1);
        drive();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_in_ready_bp", 64'(in_ready), 64'd0);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_data", 64'(out_data), 64'hB001);
            chk("t4_hold_ch", 64'(out_ch), 64'd1);
            chk("t4_hold_last", 64'(out_last), 64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("t4_in_ready_rel", 64'(in_ready), 64'b0010);
        step();
        chk("t4_next_data", 64'(out_data), 64'hB002);
        chk("t4_next_last", 64'(out_last), 64'd1);
        drain(10);
        step();
        chk("t4_empty", 64'(out_valid), 64'd0);

        // 5: N=3 instance, out-of-range select then a legal one
        mode3 = 1'b0; sel3 = 2'd3;
        in_valid3 = 3'b111; in_last3 = 3'b111;
        in_data3 = {16'hC002, 16'hC001, 16'hC000};
        #1;
        chk("t5_oor_ready", 64'(in_ready3), 64'd0);
        step();
        chk("t5_oor_valid_a", 64'(out_valid3), 64'd0);
        step();
        chk("t5_oor_valid_b", 64'(out_valid3), 64'd0);
        sel3 = 2'd1;
        #1;
        chk("t5_sel1_ready", 64'(in_ready3), 64'b010);
        step();
        in_valid3 = '0;
        chk("t5_out_valid", 64'(out_valid3), 64'd1);
        chk("t5_out_ch", 64'(out_ch3), 64'd1);
        chk("t5_out_data", 64'(out_data3), 64'hC001);

        // 6: asynchronous reset in the middle of a locked packet on ch2
        mode = 1'b0; sel = 2'd2;
        push_src(2, 16'hD001, 1'b0);
        push_src(2, 16'hD002, 1'b0);
        push_src(2, 16'hD003, 1'b1);
        push_exp(2, 16'hD001, 1'b0);
        drive();
        step();
        chk("t6_locked", 64'(dut.state), 64'(ST_LOCKED));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_state", 64'(dut.state), 64'(ST_IDLE));
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        step();
        step();
        rst_n = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            push_src(i, 16'hE000 + 16'(i), 1'b1);
            push_exp(i, 16'hE000 + 16'(i), 1'b1);
        end
        drive();
        #1;
        chk("t6_first_rr", 64'(in_ready), 64'b0001);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Registered N-to-1 stream multiplexer with valid/ready handshake and packet lock; successor to the plain two-input combinational muxes.
- Merges feature-map / partial-sum streams from N producers in the CNN datapath into one consumer.
- Two modes: external select, or internal round-robin arbitration. Grant is held for a whole packet, up to the input `last` beat.

Parameters:
- WIDTH, 16, data bits per beat.
- N, 4, number of input channels (N >= 2).
- SEL_W, $clog2(N), select and channel-id width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = external select, 1 = round-robin.
- sel  input  SEL_W  channel select; used only when mode=0.
- in_valid  input  N  per-channel valid.
- in_last  input  N  per-channel end-of-packet flag.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; at most one bit high.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_ch  output  SEL_W  source channel of the held beat.
- out_ready  input  1  consumer ready.

Behaviour:
- **Reset.** rst_n low clears the following immediately, regardless of clk:
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - state=IDLE, grant_q=0, rr_ptr=0.
  - in_ready=0 while rst_n is low.
- **Space.** space = !out_valid || out_ready (single output register, full throughput).
- **Effective grant g.** Combinational:
  - LOCKED: g = grant_q.
  - IDLE, mode=0: g = sel if sel < N, else no grant.
  - IDLE, mode=1: g = first i with in_valid[i] set, searching rr_ptr, rr_ptr+1, ... mod N. No grant if all in_valid are 0.
- **Ready.** in_ready[g] = space when a grant exists; all other in_ready bits are 0. in_ready never depends on in_valid of the same channel.
- **Transfer.**
  - A transfer occurs when in_valid[g] && in_ready[g].
  - On the next edge: out_data <= in_data[g], out_last <= in_last[g], out_ch <= g, out_valid <= 1.
  - Latency is exactly 1 cycle from input acceptance to out_valid.
- **Drain.** If out_valid && out_ready and no transfer occurs, out_valid <= 0. out_data, out_last and out_ch hold their values.
- **State machine.**
  - IDLE -> LOCKED on a transfer with in_last[g]=0; grant_q <= g.
  - IDLE stays IDLE on a transfer with in_last[g]=1 (single-beat packet); rr_ptr <= (g+1) mod N.
  - LOCKED -> IDLE on a transfer with in_last[grant_q]=1; rr_ptr <= (grant_q+1) mod N.
  - LOCKED stays LOCKED on any other cycle.
- **Mode and select changes.**
  - Changes to mode or sel while LOCKED are ignored until return to IDLE.
  - rr_ptr updates only on packet end, in both modes.
- **Boundary conditions.**
  - Out-of-range sel (sel >= N, N not a power of 2) in IDLE with mode=0: no grant, all in_ready=0, no state change.
  - Back-pressure: out_ready=0 with out_valid=1 holds out_* stable and drives all in_ready=0.
  - Locked channel deasserts in_valid mid-packet: the lock is kept and other channels wait (no interleaving).
  - rr_ptr wrap: the search wraps N-1 -> 0.
  - Reset mid-packet: the lock and the held beat are discarded. The first packet after reset starts from channel 0 priority.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_SEL=1'b0, MODE_RR=1'b1} mux_mode_t.
  - typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_valid, gnt_idx[SEL_W].
  - Purely combinational rotate-priority search.
  - Instantiated once; owns no state (rr_ptr lives in stream_mux_n).

Test Plan:
1. mode=0, sel=2, in_valid=4'b0100, in_data[2]=16'hA5A5, last=1, out_ready=1 -> in_ready=4'b0100. Next cycle: out_valid=1, out_data=A5A5, out_ch=2, out_last=1. Back in IDLE, rr_ptr=3.
2. mode=1, all four channels valid with single-beat packets, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
3. mode=1, ch1 sends a 3-beat packet while ch0 and ch3 are valid throughout -> out_ch=1,1,1, then 3, then 0. in_ready[0] and in_ready[3] stay 0 during the packet.
4. Beat held with out_ready=0 for 5 cycles -> out_data, out_ch and out_last stable; all in_ready=0. Release out_ready -> the next beat appears 1 cycle after acceptance with no lost or duplicated beat.
5. N=3, mode=0, sel=3, all channels valid -> in_ready=0 and out_valid stays 0. Switch sel=1 -> ch1 is granted on the same cycle.
6. Assert rst_n=0 between clock edges in the middle of a LOCKED packet on ch2 -> out_valid=0 and in_ready=0 immediately. After release, mode=1 with all channels valid grants ch0 first.
